// File: rtl/pixgen_pkg.sv
// pixgen_pkg -- shared definitions for the synthetic pixel stream generator.
//
// Holds the register map, CTRL bit position, register reset values, the default
// frame geometry, the packing phase type and the per-pixel colour function.
//
// Optional feature macro: PIXGEN_FRAME_COUNT_EN (adds the FRAMES register).

package pixgen_pkg;

  // Default frame geometry: 640 RGB888 pixels = 1920 bytes = 480 32-bit words.
  localparam int X_WORDS_DEFAULT = 480;
  localparam int Y_LINES_DEFAULT = 480;

  // Register byte addresses on the AXI4-Lite slave.
  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_CB     = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_FRAMES = 8'h0C;

  localparam int          CTRL_EN_BIT     = 0;
  localparam logic        CTRL_EN_DEFAULT = 1'b1;
  localparam logic [23:0] CB_DEFAULT      = 24'h00_0000;

  // Position inside the 3-word / 4-pixel packing cycle.
  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_t;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } rgb_t;

  // Colour of pixel p on line y. Only the low bytes of p and y can influence
  // the mod-256 result, so callers pass just those bytes.
  function automatic rgb_t pixel_color(input logic [7:0]  p8,
                                       input logic [7:0]  y8,
                                       input logic [23:0] cb);
    rgb_t c;
    c.r = p8 + cb[7:0];
    c.g = y8 + cb[15:8];
    c.b = (p8 ^ y8) + cb[23:16];
    return c;
  endfunction

endpackage

// File: rtl/pixgen_axil_regs.sv
// pixgen_axil_regs -- AXI4-Lite slave and register file of the pixel generator.
//
// Ports:
//   clk, rst                 shared clock, asynchronous active-high reset
//   s_axi_lite_aw*/w*/b*     write channels (8-bit address, 32-bit data)
//   s_axi_lite_ar*/r*        read channels
//   ctrl_en                  CTRL.EN live value
//   cb                       colour base live value
//   status_y, status_stall   live STATUS fields from the stream side
//   frame_count              completed-frame count (PIXGEN_FRAME_COUNT_EN only)
//
// Map: 0x00 CTRL (bit0 EN), 0x04 CB [23:0], 0x08 STATUS RO, 0x0C FRAMES RO
// (reads 0 unless PIXGEN_FRAME_COUNT_EN is defined). Unmapped or unaligned
// reads return 0; unmapped writes are dropped but still answered OKAY.

module pixgen_axil_regs
  import pixgen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axi_lite_awaddr,
  input  logic        s_axi_lite_awvalid,
  output logic        s_axi_lite_awready,
  input  logic [31:0] s_axi_lite_wdata,
  input  logic        s_axi_lite_wvalid,
  output logic        s_axi_lite_wready,
  output logic [1:0]  s_axi_lite_bresp,
  output logic        s_axi_lite_bvalid,
  input  logic        s_axi_lite_bready,
  input  logic [7:0]  s_axi_lite_araddr,
  input  logic        s_axi_lite_arvalid,
  output logic        s_axi_lite_arready,
  output logic [31:0] s_axi_lite_rdata,
  output logic [1:0]  s_axi_lite_rresp,
  output logic        s_axi_lite_rvalid,
  input  logic        s_axi_lite_rready,
  output logic        ctrl_en,
  output logic [23:0] cb,
  input  logic [8:0]  status_y,
  input  logic        status_stall
`ifdef PIXGEN_FRAME_COUNT_EN
  ,
  input  logic [31:0] frame_count
`endif
);

  logic        wr_fire;
  logic        rd_fire;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  assign s_axi_lite_bresp = 2'b00;
  assign s_axi_lite_rresp = 2'b00;

  // awready and wready rise together, so one of them is enough to qualify.
  assign wr_fire = s_axi_lite_awready && s_axi_lite_awvalid && s_axi_lite_wvalid;
  assign rd_fire = s_axi_lite_arready && s_axi_lite_arvalid;

  // No register stores the top byte of a write.
  assign unused_wdata = &{1'b0, s_axi_lite_wdata[31:24]};

  // Write channel: single-cycle ready pulse, then hold bvalid until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axi_lite_awready <= 1'b0;
      s_axi_lite_wready  <= 1'b0;
      s_axi_lite_bvalid  <= 1'b0;
      ctrl_en            <= CTRL_EN_DEFAULT;
      cb                 <= CB_DEFAULT;
    end else begin
      s_axi_lite_awready <= 1'b0;
      s_axi_lite_wready  <= 1'b0;
      if (s_axi_lite_awvalid && s_axi_lite_wvalid && !s_axi_lite_bvalid && !s_axi_lite_awready) begin
        s_axi_lite_awready <= 1'b1;
        s_axi_lite_wready  <= 1'b1;
      end
      if (wr_fire) begin
        s_axi_lite_bvalid <= 1'b1;
        case (s_axi_lite_awaddr)
          ADDR_CTRL: ctrl_en <= s_axi_lite_wdata[CTRL_EN_BIT];
          ADDR_CB:   cb      <= s_axi_lite_wdata[23:0];
          default:   ;
        endcase
      end else if (s_axi_lite_bvalid && s_axi_lite_bready) begin
        s_axi_lite_bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    case (s_axi_lite_araddr)
      ADDR_CTRL:   rd_mux = {31'h0, ctrl_en};
      ADDR_CB:     rd_mux = {8'h0, cb};
      ADDR_STATUS: rd_mux = {22'h0, status_stall, status_y};
`ifdef PIXGEN_FRAME_COUNT_EN
      ADDR_FRAMES: rd_mux = frame_count;
`endif
      default:     rd_mux = 32'h0;
    endcase
  end

  // Read channel: single-cycle arready pulse, registered rdata held with rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axi_lite_arready <= 1'b0;
      s_axi_lite_rvalid  <= 1'b0;
      s_axi_lite_rdata   <= 32'h0;
    end else begin
      s_axi_lite_arready <= 1'b0;
      if (s_axi_lite_arvalid && !s_axi_lite_rvalid && !s_axi_lite_arready) begin
        s_axi_lite_arready <= 1'b1;
      end
      if (rd_fire) begin
        s_axi_lite_rvalid <= 1'b1;
        s_axi_lite_rdata  <= rd_mux;
      end else if (s_axi_lite_rvalid && s_axi_lite_rready) begin
        s_axi_lite_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pixel_stream_gen.sv
// pixel_stream_gen -- synthetic RGB888 video source on a 32-bit AXI4-Stream.
//
// Streams X_WORDS x Y_LINES frames continuously from reset; four pixels are
// packed into every three words, byte order R0,G0,B0,R1,... low byte first.
// tuser marks the first word of a frame, tlast the last word of each line.
//
// Ports:
//   out_stream_aclk          single clock (stream and AXI-Lite)
//   axi_reset                asynchronous active-high reset
//   out_stream_t*            AXI4-Stream master (tkeep constant 4'hF)
//   s_axi_lite_*             AXI4-Lite slave, see pixgen_axil_regs
//
// Optional feature macro: PIXGEN_FRAME_COUNT_EN adds a 32-bit completed-frame
// counter readable at 0x0C.

module pixel_stream_gen
  import pixgen_pkg::*;
#(
  parameter int X_WORDS = X_WORDS_DEFAULT,  // multiple of 3, at most 511
  parameter int Y_LINES = Y_LINES_DEFAULT   // at most 512
) (
  input  logic        out_stream_aclk,
  input  logic        axi_reset,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready,
  input  logic [7:0]  s_axi_lite_awaddr,
  input  logic        s_axi_lite_awvalid,
  output logic        s_axi_lite_awready,
  input  logic [31:0] s_axi_lite_wdata,
  input  logic        s_axi_lite_wvalid,
  output logic        s_axi_lite_wready,
  output logic [1:0]  s_axi_lite_bresp,
  output logic        s_axi_lite_bvalid,
  input  logic        s_axi_lite_bready,
  input  logic [7:0]  s_axi_lite_araddr,
  input  logic        s_axi_lite_arvalid,
  output logic        s_axi_lite_arready,
  output logic [31:0] s_axi_lite_rdata,
  output logic [1:0]  s_axi_lite_rresp,
  output logic        s_axi_lite_rvalid,
  input  logic        s_axi_lite_rready
);

  logic        ctrl_en;
  logic [23:0] cb_live;
  logic [23:0] cb_shadow;
  logic [23:0] cb_use;

  // Generator position of the next word to be loaded into the output register.
  logic [8:0]  x;
  logic [8:0]  y;
  phase_t      phase;
  // Pixel index of the first pixel of the current 4-pixel group. Only its low
  // byte reaches the colour math, so an 8-bit counter wrapping at 256 is exact.
  logic [7:0]  pix_base;
  // G and B of the pixel that straddles the previous word boundary; its R
  // byte always fits in the earlier word, so it is never deferred.
  logic [15:0] carry;
  logic [15:0] carry_next;

  logic [8:0]  out_y;
  rgb_t        col_a;
  rgb_t        col_b;
  logic [31:0] word_next;
  logic        sof_next;
  logic        eol_next;
  logic        load_ok;
  logic        gen_ok;
  logic        stall;

  assign out_stream_tkeep = 4'hF;
  assign stall            = out_stream_tvalid && !out_stream_tready;

  // The output register may be refilled when it is empty or being drained.
  assign load_ok = !out_stream_tvalid || out_stream_tready;
  // A new frame only starts while enabled; a running frame always completes.
  assign gen_ok  = !sof_next || ctrl_en;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sof_next   = (x == 9'd0) && (y == 9'd0);
    eol_next   = (x == 9'(X_WORDS - 1));
    // Colour base is captured at the first word of a frame; that word itself
    // uses the live value, the rest of the frame the captured copy.
    cb_use     = sof_next ? cb_live : cb_shadow;
    col_a      = '0;
    col_b      = pixel_color(pix_base + 8'd1, y[7:0], cb_use);
    word_next  = 32'h0;
    carry_next = carry;
    unique case (phase)
      PH0: begin
        // R0 G0 B0 | R1, keep G1 B1 for the next word.
        col_a      = pixel_color(pix_base, y[7:0], cb_use);
        word_next  = {col_b.r, col_a.b, col_a.g, col_a.r};
        carry_next = {col_b.b, col_b.g};
      end
      PH1: begin
        // G1 B1 | R2 G2, keep B2.
        col_a      = pixel_color(pix_base + 8'd2, y[7:0], cb_use);
        word_next  = {col_a.g, col_a.r, carry[15:8], carry[7:0]};
        carry_next = {col_a.b, col_a.g};
      end
      PH2: begin
        // B2 | R3 G3 B3.
        col_a      = pixel_color(pix_base + 8'd3, y[7:0], cb_use);
        word_next  = {col_a.b, col_a.g, col_a.r, carry[15:8]};
        carry_next = {col_a.b, col_a.g};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge out_stream_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      out_stream_tdata  <= 32'h0;
      out_stream_tlast  <= 1'b0;
      out_stream_tuser  <= 1'b0;
      out_stream_tvalid <= 1'b0;
      out_y             <= 9'd0;
      x                 <= 9'd0;
      y                 <= 9'd0;
      phase             <= PH0;
      pix_base          <= 8'd0;
      carry             <= 16'h0;
      cb_shadow         <= CB_DEFAULT;
    end else if (load_ok) begin
      if (gen_ok) begin
        out_stream_tdata  <= word_next;
        out_stream_tlast  <= eol_next;
        out_stream_tuser  <= sof_next;
        out_stream_tvalid <= 1'b1;
        out_y             <= y;
        carry             <= carry_next;
        if (sof_next) begin
          cb_shadow <= cb_live;
        end
        if (eol_next) begin
          x        <= 9'd0;
          phase    <= PH0;
          pix_base <= 8'd0;
          y        <= (y == 9'(Y_LINES - 1)) ? 9'd0 : y + 9'd1;
        end else begin
          x <= x + 9'd1;
          unique case (phase)
            PH0:     phase <= PH1;
            PH1:     phase <= PH2;
            default: begin
              phase    <= PH0;
              pix_base <= pix_base + 8'd4;
            end
          endcase
        end
      end else begin
        // Disabled at a frame boundary: drain and idle until EN returns.
        out_stream_tvalid <= 1'b0;
        out_stream_tlast  <= 1'b0;
        out_stream_tuser  <= 1'b0;
      end
    end
  end

`ifdef PIXGEN_FRAME_COUNT_EN
  logic [31:0] frame_count;

  always_ff @(posedge out_stream_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      frame_count <= 32'h0;
    end else if (out_stream_tvalid && out_stream_tready && out_stream_tlast &&
                 (out_y == 9'(Y_LINES - 1))) begin
      frame_count <= frame_count + 32'd1;
    end
  end
`endif

  pixgen_axil_regs u_regs (
    .clk                (out_stream_aclk),
    .rst                (axi_reset),
    .s_axi_lite_awaddr  (s_axi_lite_awaddr),
    .s_axi_lite_awvalid (s_axi_lite_awvalid),
    .s_axi_lite_awready (s_axi_lite_awready),
    .s_axi_lite_wdata   (s_axi_lite_wdata),
    .s_axi_lite_wvalid  (s_axi_lite_wvalid),
    .s_axi_lite_wready  (s_axi_lite_wready),
    .s_axi_lite_bresp   (s_axi_lite_bresp),
    .s_axi_lite_bvalid  (s_axi_lite_bvalid),
    .s_axi_lite_bready  (s_axi_lite_bready),
    .s_axi_lite_araddr  (s_axi_lite_araddr),
    .s_axi_lite_arvalid (s_axi_lite_arvalid),
    .s_axi_lite_arready (s_axi_lite_arready),
    .s_axi_lite_rdata   (s_axi_lite_rdata),
    .s_axi_lite_rresp   (s_axi_lite_rresp),
    .s_axi_lite_rvalid  (s_axi_lite_rvalid),
    .s_axi_lite_rready  (s_axi_lite_rready),
    .ctrl_en            (ctrl_en),
    .cb                 (cb_live),
    .status_y           (out_y),
    .status_stall       (stall)
`ifdef PIXGEN_FRAME_COUNT_EN
    ,
    .frame_count        (frame_count)
`endif
  );

endmodule

// File: tb/tb_pixel_stream_gen.sv
// tb_pixel_stream_gen -- randomized self-checking bench for pixel_stream_gen.
//
// A reduced frame geometry (6 words = 8 pixels per line, 4 lines) keeps whole
// frames short. Expected words come from a byte-stream model of the colour
// rules; position, SOF/EOL, stall stability and register reads are checked.

module tb_pixel_stream_gen;

  localparam int XW = 6;
  localparam int YL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tuser;
  logic        tvalid;
  logic        tready = 1'b1;
  logic [7:0]  awaddr = 8'h0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = 32'h0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  araddr = 8'h0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  always #5 clk = ~clk;

  pixel_stream_gen #(.X_WORDS(XW), .Y_LINES(YL)) dut (
    .out_stream_aclk    (clk),
    .axi_reset          (rst),
    .out_stream_tdata   (tdata),
    .out_stream_tkeep   (tkeep),
    .out_stream_tlast   (tlast),
    .out_stream_tuser   (tuser),
    .out_stream_tvalid  (tvalid),
    .out_stream_tready  (tready),
    .s_axi_lite_awaddr  (awaddr),
    .s_axi_lite_awvalid (awvalid),
    .s_axi_lite_awready (awready),
    .s_axi_lite_wdata   (wdata),
    .s_axi_lite_wvalid  (wvalid),
    .s_axi_lite_wready  (wready),
    .s_axi_lite_bresp   (bresp),
    .s_axi_lite_bvalid  (bvalid),
    .s_axi_lite_bready  (bready),
    .s_axi_lite_araddr  (araddr),
    .s_axi_lite_arvalid (arvalid),
    .s_axi_lite_arready (arready),
    .s_axi_lite_rdata   (rdata),
    .s_axi_lite_rresp   (rresp),
    .s_axi_lite_rvalid  (rvalid),
    .s_axi_lite_rready  (rready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: byte i of a line belongs to pixel i/3, component i%3 (R,G,B).
  function automatic logic [31:0] model_word(input logic [23:0] cbv, input int wx, input int wy);
    logic [31:0] w;
    logic [7:0]  b;
    w = 32'h0;
    for (int k = 0; k < 4; k++) begin
      int i;
      int p;
      i = 4 * wx + k;
      p = i / 3;
      case (i % 3)
        0:       b = 8'(p) + cbv[7:0];
        1:       b = 8'(wy) + cbv[15:8];
        default: b = 8'(p ^ wy) + cbv[23:16];
      endcase
      w[8*k +: 8] = b;
    end
    return w;
  endfunction

  // Model state: position of the next word expected on the bus.
  int          mx = 0;
  int          my = 0;
  int          frames_seen = 0;
  logic [23:0] cb_model = 24'h0;
  logic [23:0] frame_cb = 24'h0;
  logic        stall_prev = 1'b0;
  logic [33:0] prev_bus = '0;
  logic [31:0] sof_word = 32'h0;
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: held low

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tready = 1'b1;
      1:       tready = 1'($urandom_range(0, 1));
      default: tready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      mx = 0;
      my = 0;
      frames_seen = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", {29'h0, tvalid, tuser, tlast, tdata}, {29'h0, 1'b1, prev_bus});
      if (tvalid && tready) begin
        if (mx == 0 && my == 0) begin
          frame_cb = cb_model;
          sof_word = tdata;
        end
        check($sformatf("word_x%0d_y%0d", mx, my), {30'h0, tuser, tlast, tdata},
              {30'h0, (mx == 0 && my == 0), (mx == XW - 1), model_word(frame_cb, mx, my)});
        check("tkeep", {60'h0, tkeep}, 64'hF);
        if (mx == XW - 1) begin
          mx = 0;
          if (my == YL - 1) begin
            my = 0;
            frames_seen++;
          end else begin
            my++;
          end
        end else begin
          mx++;
        end
      end
      stall_prev = tvalid && !tready;
      prev_bus   = {tuser, tlast, tdata};
    end
  end

  task automatic wait_pos(input int tx, input int ty, input string tag);
    int n;
    n = 0;
    while (!(mx == tx && my == ty) && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, (mx == tx && my == ty), 1);
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n;
    n = 0;
    while (frames_seen < target && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, (frames_seen >= target), 1);
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d);
    int n;
    @(posedge clk); #1;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(awready && wready) && n < 20);
    check("aw_w_ready", awready && wready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    check("bvalid", bvalid, 1);
    check("bresp", bresp, 0);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d);
    int n;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    check("arready", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    check("rvalid", rvalid, 1);
    check("rresp", rresp, 0);
    d = rdata;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_frames;
    int          n;
    int          f0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_state", {24'h0, tvalid, tlast, tuser, tdata, awready, wready, bvalid, arready, rvalid}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("first_word", {31'h0, tvalid, tuser, tdata}, {31'h0, 1'b1, 1'b1, 32'h0100_0000});

    // Two frames with a always-ready sink.
    wait_frames(2, "two_frames_ready");

    // Two frames with random backpressure.
    ready_mode = 1;
    wait_frames(frames_seen + 2, "two_frames_random");

    // Colour base change mid-frame lands at the next SOF.
    wait_pos(0, 1, "reach_mid_frame");
    axi_write(8'h04, 32'h0000_0010);
    cb_model = 24'h00_0010;
    wait_frames(frames_seen + 1, "frame_after_cb");
    wait_pos(1, 0, "sof_after_cb");
    check("cb_sof_word", sof_word, 32'h1100_0010);

    // Register reads while the sink stalls.
    ready_mode = 2;
    repeat (3) @(negedge clk);
    #1;
    axi_read(8'h08, rd);
    check("status_live", rd, {22'h0, 1'b1, 9'(my)});
    axi_read(8'h00, rd);
    check("ctrl_read", rd, 32'h1);
    axi_read(8'h04, rd);
    check("cb_read", rd, 32'h0000_0010);
    axi_read(8'h3C, rd);
    check("unmapped_read", rd, 32'h0);
`ifdef PIXGEN_FRAME_COUNT_EN
    exp_frames = 32'(frames_seen);
`else
    exp_frames = 32'h0;
`endif
    axi_read(8'h0C, rd);
    check("frames_read", rd, exp_frames);
    axi_write(8'h08, 32'hFFFF_FFFF);
    axi_write(8'h3C, 32'h0000_0001);
    axi_read(8'h08, rd);
    check("status_ro", rd, {22'h0, 1'b1, 9'(my)});

    // Back-to-back writes with bready low: bvalid holds, second write waits.
    @(posedge clk); #1;
    awaddr = 8'h04; wdata = 32'h0000_0010; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(awready && wready) && n < 20);
    check("b2b_first_accept", awready && wready, 1);
    @(posedge clk); #1;
    wdata = 32'h0000_0020;
    repeat (4) @(negedge clk);
    check("bvalid_held", {bvalid, awready, bresp}, 4'b1000);
    @(posedge clk); #1;
    bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(awready && wready) && n < 20);
    check("b2b_second_accept", awready && wready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    check("b2b_bvalid_cleared", bvalid, 0);
    bready = 1'b0;
    cb_model = 24'h00_0020;
    axi_read(8'h04, rd);
    check("cb_read_b2b", rd, 32'h0000_0020);

    // EN=0 mid-frame: frame completes, stream idles, EN=1 resumes at SOF.
    ready_mode = 0;
    wait_pos(0, 1, "reach_mid_frame_en");
    axi_write(8'h00, 32'h0);
    f0 = frames_seen;
    wait_frames(f0 + 1, "frame_done_en0");
    @(negedge clk);
    check("idle_after_en0_a", tvalid, 0);
    repeat (10) @(negedge clk);
    check("idle_after_en0_b", {32'(frames_seen), 31'h0, tvalid}, {32'(f0 + 1), 32'h0});
    axi_read(8'h00, rd);
    check("ctrl_read_0", rd, 32'h0);
    axi_write(8'h00, 32'h1);
    wait_pos(1, 0, "resume_sof");

    // Asynchronous reset mid-line.
    wait_pos(3, 2, "reach_mid_line");
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_drop", tvalid, 0);
    cb_model = 24'h0;
    repeat (2) @(negedge clk);
    check("reset_state_2", {24'h0, tvalid, tlast, tuser, tdata, awready, wready, bvalid, arready, rvalid}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("first_word_2", {31'h0, tvalid, tuser, tdata}, {31'h0, 1'b1, 1'b1, 32'h0100_0000});
    axi_read(8'h0C, rd);
    check("frames_after_rst", rd, 32'h0);
    wait_frames(2, "two_frames_after_rst");
`ifdef PIXGEN_FRAME_COUNT_EN
    exp_frames = 32'd2;
`else
    exp_frames = 32'h0;
`endif
    axi_read(8'h0C, rd);
    check("frames_two", rd, exp_frames);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
